// File: rtl/gate_unit_arbiter.sv
// gate_unit_arbiter
// Two requesters share one bitwise gate unit. Round-robin arbitration picks
// at most one request per cycle, the result lands in a single registered
// response slot, and each response carries the id of its requester.
//
// Handshake: a transfer happens on a port at a rising edge where valid and
// ready are both high. Once raised, valid stays high with stable payload
// until its transfer. A response is held stable while rsp_valid is high and
// rsp_ready is low. reqN_ready may depend on both valids, so clients must
// not gate valid on ready.
module gate_unit_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  // Response slot occupancy; rsp_valid is a direct decode of this state.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  slot_state_e      state_q, state_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic             last_grant_q, last_grant_d;

  logic             slot_free;
  logic             grant_valid;
  logic             grant_id;
  logic             accept;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] gate_result;
  logic             op_illegal;

  // Round-robin grant: a lone requester wins outright, a tie goes to the
  // requester that did not win last time.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req0_valid && !req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (!req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end else if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = ~last_grant_q;
    end
  end

  // Ready/accept: the slot may refill in the same cycle it drains.
  always_comb begin
    slot_free  = (state_q == SLOT_EMPTY) | rsp_ready;
    req0_ready = slot_free & grant_valid & (grant_id == 1'b0) & req0_valid;
    req1_ready = slot_free & grant_valid & (grant_id == 1'b1) & req1_valid;
    accept     = req0_ready | req1_ready;
  end

  // Operand mux in front of the shared gate unit.
  always_comb begin
    sel_op = grant_id ? req1_op : req0_op;
    sel_a  = grant_id ? req1_a  : req0_a;
    sel_b  = grant_id ? req1_b  : req0_b;
  end

  // Per-lane mux-built gate: operand a selects between b-derived values.
  always_comb begin
    gate_result = '0;
    op_illegal  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (sel_op)
        OP_AND:  gate_result[i] = sel_a[i] ? sel_b[i]  : 1'b0;
        OP_OR:   gate_result[i] = sel_a[i] ? 1'b1      : sel_b[i];
        OP_NAND: gate_result[i] = sel_a[i] ? ~sel_b[i] : 1'b1;
        OP_NOR:  gate_result[i] = sel_a[i] ? 1'b0      : ~sel_b[i];
        OP_XOR:  gate_result[i] = sel_a[i] ? ~sel_b[i] : sel_b[i];
        OP_XNOR: gate_result[i] = sel_a[i] ? sel_b[i]  : ~sel_b[i];
        default: gate_result[i] = 1'b0;
      endcase
    end
    if (sel_op > OP_XNOR) begin
      op_illegal = 1'b1;
    end
  end

  // Slot next-state: load on accept, empty on drain, otherwise hold.
  always_comb begin
    state_d      = state_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      state_d      = SLOT_FULL;
      rsp_id_d     = grant_id;
      rsp_data_d   = gate_result;
      rsp_err_d    = op_illegal;
      last_grant_d = grant_id;
    end else if ((state_q == SLOT_FULL) && rsp_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  // Slot and arbitration registers; reset discards any held response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SLOT_EMPTY;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Output drive.
  always_comb begin
    rsp_valid = (state_q == SLOT_FULL);
    rsp_id    = rsp_id_q;
    rsp_data  = rsp_data_q;
    rsp_err   = rsp_err_q;
  end

endmodule
